// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit adder computing CHUNK bits per cycle; define SUBTRACT_EN to add the op port (a - b).
// Latency WIDTH/CHUNK cycles from accept to done; start is ignored (not queued) while busy.
module multicycle_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
`ifdef SUBTRACT_EN
   input  logic             op,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = $clog2(N + 1);

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("multicycle_adder: CHUNK must divide WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry;
   logic [CW-1:0]    idx;
`ifdef SUBTRACT_EN
   logic             op_r;
`endif

   int               base;
   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] b_eff;
   logic [CHUNK:0]   sl_sum;
   logic             msb_cin;
   logic             last;
   logic [WIDTH-1:0] sum_nxt;

   always_comb begin
      base    = int'(idx) * CHUNK;
      a_sl    = a_r[base +: CHUNK];
      b_sl    = b_r[base +: CHUNK];
`ifdef SUBTRACT_EN
      b_eff   = op_r ? ~b_sl : b_sl;
`else
      b_eff   = b_sl;
`endif
      sl_sum  = {1'b0, a_sl} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry};
      // Carry into the word MSB, recovered from the MSB's sum and operand bits.
      msb_cin = sl_sum[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_eff[CHUNK-1];
      last    = (idx == CW'(N - 1));
      sum_nxt = sum;
      sum_nxt[base +: CHUNK] = sl_sum[CHUNK-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         carry     <= 1'b0;
         idx       <= '0;
`ifdef SUBTRACT_EN
         op_r      <= 1'b0;
`endif
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
`ifdef SUBTRACT_EN
                  op_r  <= op;
                  carry <= op ? 1'b1 : carry_in;
`else
                  carry <= carry_in;
`endif
                  idx   <= '0;
                  sum   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sum   <= sum_nxt;
               carry <= sl_sum[CHUNK];
               if (last) begin
                  carry_out <= sl_sum[CHUNK];
                  overflow  <= msb_cin ^ sl_sum[CHUNK];
                  zero      <= (sum_nxt == '0);
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
